// File: rtl/io_arb_pkg.sv
// Shared types for the IO access arbiter: FSM states, requester ids and the latched command.
package io_arb_pkg;

  // Command address is stored at a fixed maximum width; the top zero-extends into it.
  localparam int IO_AW_MAX = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    SAMPLE,
    DONE
  } state_t;

  typedef enum logic {
    CPU = 1'b0,
    DBG = 1'b1
  } port_t;

  typedef struct packed {
    logic                 we;
    logic [IO_AW_MAX-1:0] addr;
    logic                 wdata;
    port_t                port;
  } io_cmd_t;

endpackage

// File: rtl/io_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port that did not win last.
module io_rr_pick
  import io_arb_pkg::*;
(
  input  logic  cpu_req_i,
  input  logic  dbg_req_i,
  input  port_t last_grant_i,
  output port_t grant_o,
  output logic  valid_o
);

  always_comb begin
    grant_o = CPU;
    if (cpu_req_i && dbg_req_i) grant_o = (last_grant_i == CPU) ? DBG : CPU;
    else if (dbg_req_i)         grant_o = DBG;
  end

  assign valid_o = cpu_req_i | dbg_req_i;

endmodule

// File: rtl/io_arbiter.sv
// Arbitrates the core and debug ports onto the shared IO block and sequences each access
// through setup / strobe / sample so address and data bracket the write edge.
module io_arbiter
  import io_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int OUTPUT_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_wdata,
  output logic                  cpu_ack,
  output logic                  cpu_rdata,
  output logic                  cpu_err,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic                  dbg_wdata,
  output logic                  dbg_ack,
  output logic                  dbg_rdata,
  output logic                  dbg_err,
  output logic                  io_write,
  output logic [ADDR_WIDTH-1:0] io_address,
  output logic                  io_data_in,
  input  logic                  io_data_out
);

  localparam int SW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
  localparam logic [IO_AW_MAX-1:0] OUT_LIM = IO_AW_MAX'(OUTPUT_SIZE);

  state_t                  state_q;
  io_cmd_t                 cmd_q, pick_cmd;
  port_t                   last_grant_q, grant;
  logic                    pick_vld;
  logic [OUTPUT_SIZE-1:0]  shadow_q;
  logic                    io_write_q, io_data_q;
  logic [ADDR_WIDTH-1:0]   io_addr_q;
  logic                    cpu_ack_q, cpu_err_q, cpu_rdata_q;
  logic                    dbg_ack_q, dbg_err_q, dbg_rdata_q;
  logic                    cmd_out, enter_done, bad_wr, rd_val;

  io_rr_pick u_pick (
    .cpu_req_i    (cpu_req),
    .dbg_req_i    (dbg_req),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .valid_o      (pick_vld)
  );

  always_comb begin
    pick_cmd = '0;
    if (grant == CPU) begin
      pick_cmd.we    = cpu_we;
      pick_cmd.addr  = IO_AW_MAX'(cpu_addr);
      pick_cmd.wdata = cpu_wdata;
      pick_cmd.port  = CPU;
    end else begin
      pick_cmd.we    = dbg_we;
      pick_cmd.addr  = IO_AW_MAX'(dbg_addr);
      pick_cmd.wdata = dbg_wdata;
      pick_cmd.port  = DBG;
    end
  end

  // Output pins cannot be read back from the IO block, so they come from the shadow copy.
  assign cmd_out    = cmd_q.addr < OUT_LIM;
  assign bad_wr     = (state_q == SETUP) && cmd_q.we && !cmd_out;
  assign enter_done = bad_wr || (state_q == STROBE) || (state_q == SAMPLE);
  assign rd_val     = cmd_out ? shadow_q[cmd_q.addr[SW-1:0]] : io_data_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      last_grant_q <= DBG;
      shadow_q     <= '0;
      io_write_q   <= 1'b0;
      io_addr_q    <= '0;
      io_data_q    <= 1'b0;
      cpu_ack_q    <= 1'b0;
      cpu_err_q    <= 1'b0;
      cpu_rdata_q  <= 1'b0;
      dbg_ack_q    <= 1'b0;
      dbg_err_q    <= 1'b0;
      dbg_rdata_q  <= 1'b0;
    end else begin
      io_write_q <= (state_q == SETUP) && cmd_q.we && cmd_out;
      cpu_ack_q  <= enter_done && (cmd_q.port == CPU);
      dbg_ack_q  <= enter_done && (cmd_q.port == DBG);
      cpu_err_q  <= bad_wr && (cmd_q.port == CPU);
      dbg_err_q  <= bad_wr && (cmd_q.port == DBG);
      if (state_q == SAMPLE && cmd_q.port == CPU) cpu_rdata_q <= rd_val;
      if (state_q == SAMPLE && cmd_q.port == DBG) dbg_rdata_q <= rd_val;

      case (state_q)
        IDLE: if (pick_vld) begin
          cmd_q     <= pick_cmd;
          io_addr_q <= pick_cmd.addr[ADDR_WIDTH-1:0];
          io_data_q <= pick_cmd.wdata;
          state_q   <= SETUP;
        end
        SETUP: begin
          if (!cmd_q.we)    state_q <= SAMPLE;
          else if (cmd_out) state_q <= STROBE;
          else              state_q <= DONE;
        end
        STROBE: begin
          shadow_q[cmd_q.addr[SW-1:0]] <= cmd_q.wdata;
          state_q <= DONE;
        end
        SAMPLE: state_q <= DONE;
        DONE: begin
          last_grant_q <= cmd_q.port;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io_write   = io_write_q;
  assign io_address = io_addr_q;
  assign io_data_in = io_data_q;
  assign cpu_ack    = cpu_ack_q;
  assign cpu_err    = cpu_err_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_ack    = dbg_ack_q;
  assign dbg_err    = dbg_err_q;
  assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_io_arbiter.sv
// Self-checking bench for io_arbiter: vector table per access, a contention run and reset mid-strobe.
module tb_io_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we, cpu_wdata, dbg_req, dbg_we, dbg_wdata;
  logic [3:0] cpu_addr, dbg_addr;
  logic       cpu_ack, cpu_rdata, cpu_err, dbg_ack, dbg_rdata, dbg_err;
  logic       io_write, io_data_in, io_data_out;
  logic [3:0] io_address;
  logic [15:0] pins;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit       port;     // 0 = CPU, 1 = DBG
    bit       we;
    bit [3:0] addr;
    bit       wdata;
    bit       pin;      // value of the IO pin at addr
    bit       chk_rd;
    bit       exp_rd;
    bit       exp_err;
    int       exp_lat;
  } vec_t;

  typedef struct {
    bit port;
    bit chk_rd;
    bit rd;
    bit err;
    int lat;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];

  io_arbiter #(.ADDR_WIDTH(4), .OUTPUT_SIZE(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .io_write(io_write), .io_address(io_address), .io_data_in(io_data_in),
    .io_data_out(io_data_out)
  );

  always #5 clk = ~clk;
  assign io_data_out = pins[io_address];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   got;
    bit   ack, oack, rd, err;
    @(negedge clk);
    pins = '0;
    pins[v.addr] = v.pin;
    if (v.port == 0) begin
      cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_req = 1'b1;
    end else begin
      dbg_we = v.we; dbg_addr = v.addr; dbg_wdata = v.wdata; dbg_req = 1'b1;
    end
    sb.push_back('{v.port, v.chk_rd, v.exp_rd, v.exp_err, v.exp_lat});
    got = 0;
    for (int k = 1; k <= 8 && got == 0; k++) begin
      @(posedge clk); #1;
      chk("io_write", io_write, (v.we && v.addr < 8 && k == 2));
      if (k <= v.exp_lat) begin
        chk("io_address", io_address, v.addr);
        if (v.we) chk("io_data_in", io_data_in, v.wdata);
      end
      // Fields changing after the grant must not disturb the access in flight.
      if (k == 1) begin
        cpu_addr = ~v.addr; cpu_wdata = ~v.wdata; cpu_we = ~v.we;
        dbg_addr = ~v.addr; dbg_wdata = ~v.wdata; dbg_we = ~v.we;
      end
      ack  = v.port ? dbg_ack : cpu_ack;
      oack = v.port ? cpu_ack : dbg_ack;
      chk("other_ack", oack, 0);
      if (ack) begin
        got = k;
        rd  = v.port ? dbg_rdata : cpu_rdata;
        err = v.port ? dbg_err : cpu_err;
      end
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    e = sb.pop_front();
    if (got == 0) begin
      checks++; errors++;
      $display("FAIL ack_timeout port=%0d addr=%0d actual=none expected=ack", v.port, v.addr);
    end else begin
      chk("ack_latency", got, e.lat);
      chk("err", err, e.err);
      if (e.chk_rd) chk("rdata", rd, e.rd);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    int   n, last;
    reset = 1'b1; pins = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;

    //             port we addr wd pin chk rd err lat
    vecs[0]  = '{0, 1, 4'd3,  1, 0, 0, 0, 0, 3};
    vecs[1]  = '{1, 0, 4'd3,  0, 0, 1, 1, 0, 3};
    vecs[2]  = '{0, 1, 4'd12, 1, 0, 0, 0, 1, 2};
    vecs[3]  = '{0, 0, 4'd3,  0, 0, 1, 1, 0, 3};
    vecs[4]  = '{1, 0, 4'd4,  0, 1, 1, 0, 0, 3};
    vecs[5]  = '{1, 0, 4'd10, 0, 1, 1, 1, 0, 3};
    vecs[6]  = '{0, 0, 4'd10, 0, 0, 1, 0, 0, 3};
    vecs[7]  = '{1, 1, 4'd7,  1, 0, 0, 0, 0, 3};
    vecs[8]  = '{0, 0, 4'd7,  0, 0, 1, 1, 0, 3};
    vecs[9]  = '{1, 1, 4'd8,  1, 0, 0, 0, 1, 2};
    vecs[10] = '{0, 1, 4'd3,  0, 0, 0, 0, 0, 3};
    vecs[11] = '{1, 0, 4'd3,  0, 1, 1, 0, 0, 3};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {io_write, io_address, io_data_in, cpu_ack, cpu_err, cpu_rdata,
                        dbg_ack, dbg_err, dbg_rdata}, 0);
    @(negedge clk) reset = 1'b0;

    // Contention: CPU wins the first tie, then strict alternation every 4 cycles.
    @(negedge clk);
    pins = '0; pins[9] = 1'b1;
    cpu_we = 0; cpu_addr = 4'd1; dbg_we = 0; dbg_addr = 4'd9;
    cpu_req = 1; dbg_req = 1;
    for (int i = 0; i < 4; i++) sb.push_back('{bit'(i % 2), 1'b1, bit'(i % 2), 1'b0, 3 + 4 * i});
    n = 0; last = 0;
    for (int k = 1; k <= 24 && n < 4; k++) begin
      @(posedge clk); #1;
      chk("cont_both_ack", cpu_ack & dbg_ack, 0);
      if (io_write) chk("cont_io_write", io_write, 0);
      if (cpu_ack || dbg_ack) begin
        e = sb.pop_front();
        chk("cont_grant", dbg_ack, e.port);
        chk("cont_cycle", k, e.lat);
        chk("cont_rdata", dbg_ack ? dbg_rdata : cpu_rdata, e.rd);
        n++;
        if (n == 4) begin cpu_req = 0; dbg_req = 0; end
      end
    end
    chk("cont_count", n, 4);
    sb.delete();
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while the strobe is high aborts the write.
    @(negedge clk);
    cpu_we = 1; cpu_addr = 4'd6; cpu_wdata = 1; cpu_req = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_pre_strobe", io_write, 1);
    reset = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    chk("rst_strobe_drop", io_write, 0);
    chk("rst_no_ack", cpu_ack | dbg_ack, 0);
    chk("rst_io_address", io_address, 0);
    reset = 1'b0;
    last = 0;
    repeat (3) begin
      @(posedge clk); #1;
      last = last | int'(cpu_ack) | int'(dbg_ack);
    end
    chk("rst_no_late_ack", last, 0);
    run_vec('{1, 0, 4'd6, 0, 1, 1, 0, 0, 3});
    run_vec('{1, 0, 4'd7, 0, 1, 1, 0, 0, 3});
    run_vec('{0, 1, 4'd6, 1, 0, 0, 0, 0, 3});
    run_vec('{1, 0, 4'd6, 0, 0, 1, 1, 0, 3});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
